// File: rtl/ysyx_22050243_wbu_pkg.sv
// ysyx_22050243_pkg: load size encodings and datapath width shared by the write-back stage.
package ysyx_22050243_pkg;
  localparam int XLEN = 64;
  localparam logic [1:0] LD_B = 2'd0;
  localparam logic [1:0] LD_H = 2'd1;
  localparam logic [1:0] LD_W = 2'd2;
  localparam logic [1:0] LD_D = 2'd3;
endpackage

// File: rtl/ysyx_22050243_wbu_if.sv
// ysyx_22050243_wbu_if: MEM-to-WB handshake bundle plus the GPR write port driven by write-back.
interface ysyx_22050243_wbu_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic                  in_rd_wen;
  logic [DATA_WIDTH-1:0] in_alu_res;
  logic                  in_is_load;
  logic [1:0]            in_ld_size;
  logic                  in_ld_unsigned;
  logic [DATA_WIDTH-1:0] in_ld_data;
  logic [2:0]            in_addr_lo;
  logic                  gpr_w_en;
  logic [ADDR_WIDTH-1:0] gpr_w_addr;
  logic [DATA_WIDTH-1:0] gpr_w_data;
  modport master (
    output in_valid, in_pc, in_rd, in_rd_wen, in_alu_res, in_is_load,
           in_ld_size, in_ld_unsigned, in_ld_data, in_addr_lo,
    input  in_ready, gpr_w_en, gpr_w_addr, gpr_w_data
  );
  modport slave (
    input  in_valid, in_pc, in_rd, in_rd_wen, in_alu_res, in_is_load,
           in_ld_size, in_ld_unsigned, in_ld_data, in_addr_lo,
    output in_ready, gpr_w_en, gpr_w_addr, gpr_w_data
  );
endinterface

// File: rtl/ysyx_22050243_wbu_load_fmt.sv
// ysyx_22050243_load_fmt: shifts the raw doubleword to the load offset and sign/zero-extends by size.
module ysyx_22050243_load_fmt
  import ysyx_22050243_pkg::*;
(
  input  logic [XLEN-1:0] ld_data,
  input  logic [2:0]      addr_lo,
  input  logic [1:0]      size,
  input  logic            ld_unsigned,
  output logic [XLEN-1:0] result
);
  logic [XLEN-1:0] sh;
  logic            sgn;
  always_comb begin
    sh  = ld_data >> {addr_lo, 3'b000};
    sgn = ~ld_unsigned & (size == LD_B ? sh[7] : size == LD_H ? sh[15] : sh[31]);
    result = size == LD_D ? sh :
             size == LD_W ? {{32{sgn}}, sh[31:0]} :
             size == LD_H ? {{48{sgn}}, sh[15:0]} :
                            {{56{sgn}}, sh[7:0]};
  end
endmodule

// File: rtl/ysyx_22050243_wbu.sv
// ysyx_22050243_wbu: one-entry write-back register feeding the GPR write port and counting retirements.
// Define YSYX_22050243_WBU_TRACE_EN to add a registered difftest trace port.
module ysyx_22050243_wbu
  import ysyx_22050243_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  halt,
  ysyx_22050243_wbu_if.slave    wb,
  output logic                  retire_valid,
  output logic [63:0]           instret
`ifdef YSYX_22050243_WBU_TRACE_EN
  ,
  output logic                  trace_valid,
  output logic [DATA_WIDTH-1:0] trace_pc,
  output logic [ADDR_WIDTH-1:0] trace_rd,
  output logic [DATA_WIDTH-1:0] trace_wdata
`endif
);
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                  wen_q, wen_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [63:0]           instret_q, instret_d;
  logic [XLEN-1:0]       ld_fmt;
  logic                  retire, accept;

  ysyx_22050243_load_fmt u_load_fmt (
    .ld_data    (wb.in_ld_data),
    .addr_lo    (wb.in_addr_lo),
    .size       (wb.in_ld_size),
    .ld_unsigned(wb.in_ld_unsigned),
    .result     (ld_fmt)
  );

  // A held entry blocks the input only while halted; otherwise it retires and frees the slot this edge.
  assign retire      = valid_q & ~halt;
  assign wb.in_ready = ~valid_q | ~halt;
  assign accept      = wb.in_valid & wb.in_ready;

  always_comb begin
    valid_d   = accept | (valid_q & ~retire);
    rd_d      = accept ? wb.in_rd : rd_q;
    wen_d     = accept ? wb.in_rd_wen : wen_q;
    result_d  = accept ? (wb.in_is_load ? ld_fmt : wb.in_alu_res) : result_q;
    instret_d = instret_q + {63'd0, retire};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      rd_q      <= '0;
      wen_q     <= 1'b0;
      result_q  <= '0;
      instret_q <= '0;
    end else begin
      valid_q   <= valid_d;
      rd_q      <= rd_d;
      wen_q     <= wen_d;
      result_q  <= result_d;
      instret_q <= instret_d;
    end
  end

  assign wb.gpr_w_en   = retire & wen_q & (rd_q != '0);
  assign wb.gpr_w_addr = rd_q;
  assign wb.gpr_w_data = result_q;
  assign retire_valid  = retire;
  assign instret       = instret_q;

`ifdef YSYX_22050243_WBU_TRACE_EN
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  trace_valid_q, trace_valid_d;
  logic [DATA_WIDTH-1:0] trace_pc_q, trace_pc_d;
  logic [ADDR_WIDTH-1:0] trace_rd_q, trace_rd_d;
  logic [DATA_WIDTH-1:0] trace_wdata_q, trace_wdata_d;
  always_comb begin
    pc_d          = accept ? wb.in_pc : pc_q;
    trace_valid_d = retire;
    trace_pc_d    = pc_q;
    trace_rd_d    = rd_q;
    trace_wdata_d = result_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= '0;
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      trace_rd_q    <= '0;
      trace_wdata_q <= '0;
    end else begin
      pc_q          <= pc_d;
      trace_valid_q <= trace_valid_d;
      trace_pc_q    <= trace_pc_d;
      trace_rd_q    <= trace_rd_d;
      trace_wdata_q <= trace_wdata_d;
    end
  end
  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;
  assign trace_rd    = trace_rd_q;
  assign trace_wdata = trace_wdata_q;
`else
  logic unused_pc;
  assign unused_pc = ^wb.in_pc;
`endif
endmodule
